adc_sample_capture: RTL and testbench

ADC_SAMPLE_CAPTURE -- requirements
Module: adc_sample_capture

---
 rtl/adc_sample_capture.sv | 163 ++++++++++++++++
 tb/tb_adc_sample_capture.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_capture.sv
// adc_sample_capture: deserialises 12-bit ADC frames and queues them in a 4-deep FIFO.
// Latency: a completed word is visible on m_data/m_valid one cycle after its count==15 edge.
// Backpressure: m_ready stalls the FIFO; a word completing into a full FIFO with no pop is dropped and flags overflow.
//
// Ports:
//   clk, rst          - system clock (shared with the ADC front end), synchronous active-high reset
//   cs, dout, count   - front-end chip select (active low), serial data (MSB first), 4-bit frame bit counter
//   m_data, m_valid   - head-of-FIFO sample (0 when empty) and non-empty flag
//   m_ready           - downstream accept; pops the head when m_valid is high
//   overflow          - sticky drop flag, cleared only by rst
//   level             - FIFO occupancy 0..4
//
// Build option: define ADC_CAPTURE_OFFSET_EN to convert offset-binary codes to two's complement
// (MSB inverted) as words are pushed; otherwise raw unsigned codes are queued.

module adc_sample_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        dout,
  input  logic [3:0]  count,
  output logic [11:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  output logic [2:0]  level
);

  localparam int unsigned DEPTH = 4;

  // Capture state. Eleven bits are enough: the twelfth (LSB) is taken straight
  // from dout on the completing edge.
  logic [10:0] shift_q, shift_d;
  logic        act_q, act_d;

  // FIFO state
  logic [11:0] mem_q [DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic        ovf_q, ovf_d;
  logic [11:0] data_q, data_d;
  logic        vld_q, vld_d;

  // Per-edge events
  logic        in_window;
  logic        word_done;
  logic [11:0] raw_word;
  logic [11:0] push_word;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        bypass;

  // ---------------------------------------------------------------------------
  // Frame capture
  // ---------------------------------------------------------------------------
  // Counts 0..3 carry the ADC zero/address bits and are ignored. The window
  // 4..15 carries the sample MSB first. act_q marks a frame that started with
  // cs low at count 4 and has not seen cs high since; it is only ever set at
  // count 4, so a reset or abort mid-frame can never yield a partial word.
  assign in_window = (count >= 4'd4);
  assign raw_word  = {shift_q, dout};

  always_comb begin
    shift_d   = shift_q;
    act_d     = act_q;
    word_done = 1'b0;
    if (in_window) begin
      if (cs) begin
        act_d = 1'b0;
      end else begin
        if (count == 4'd4) begin
          act_d   = 1'b1;
          shift_d = {10'd0, dout};
        end else begin
          shift_d = {shift_q[9:0], dout};
        end
        if (count == 4'd15) begin
          word_done = act_q;
          act_d     = 1'b0;
        end
      end
    end
  end

`ifdef ADC_CAPTURE_OFFSET_EN
  // Offset-binary to two's complement: raw - 2048 is just an MSB flip.
  assign push_word = raw_word ^ 12'h800;
`else
  assign push_word = raw_word;
`endif

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // pop is qualified by the registered m_valid, so a word pushed into an empty
  // FIFO cannot be popped on the edge it arrives. When full, a simultaneous pop
  // frees the slot the push needs.
  assign full    = (level_q == 3'd4);
  assign pop     = vld_q & m_ready;
  assign push_ok = word_done & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    level_d  = level_q + {2'd0, push_ok} - {2'd0, pop};
    ovf_d    = ovf_q | (word_done & full & ~pop);
  end

  // Registered head: the next head is the entry at the new read pointer. When
  // that entry is the one being written this edge (push into empty, or push
  // and pop at occupancy 1) the memory does not hold it yet, so forward it.
  assign bypass = push_ok & (rd_ptr_d == wr_ptr_q);

  always_comb begin
    vld_d = (level_d != 3'd0);
    if (level_d == 3'd0) begin
      data_d = 12'd0;
    end else if (bypass) begin
      data_d = push_word;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      act_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      shift_q  <= shift_d;
      act_q    <= act_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_word;
      end
    end
  end

  assign m_data   = data_q;
  assign m_valid  = vld_q;
  assign overflow = ovf_q;
  assign level    = level_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
module tb_adc_sample_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        dout;
  logic [3:0]  count;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        overflow;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;
  bit rand_ready = 1'b0;

`ifdef ADC_CAPTURE_OFFSET_EN
  localparam logic [11:0] OFS = 12'h800;
`else
  localparam logic [11:0] OFS = 12'h000;
`endif

  adc_sample_capture dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .dout     (dout),
    .count    (count),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  // Free-running front-end bit counter
  initial begin
    count = 4'd0;
    forever begin
      @(posedge clk);
      #1 count = count + 4'd1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: bit position from the counter, frame goodness flag,
  // and a bounded queue of words.
  // ---------------------------------------------------------------------------
  logic [11:0] ref_q[$];
  bit          ref_ovf;
  bit          ref_good;
  bit          ref_pop;
  bit          ref_push;
  logic [11:0] ref_word;
  logic [11:0] ref_w;
  int          ref_idx;

  always @(posedge clk) begin
    if (rst) begin
      ref_q.delete();
      ref_ovf  = 1'b0;
      ref_good = 1'b0;
      ref_word = '0;
    end else begin
      ref_pop  = (ref_q.size() != 0) && (m_ready == 1'b1);
      ref_push = 1'b0;
      ref_w    = '0;
      if (int'(count) >= 4) begin
        if (cs) begin
          ref_good = 1'b0;
        end else begin
          if (int'(count) == 4) begin
            ref_good = 1'b1;
            ref_word = '0;
          end
          ref_idx = 15 - int'(count);
          ref_word[ref_idx] = dout;
          if (int'(count) == 15) begin
            ref_push = ref_good;
            ref_w    = ref_word ^ OFS;
            ref_good = 1'b0;
          end
        end
      end
      if (ref_pop) void'(ref_q.pop_front());
      if (ref_push) begin
        if (ref_q.size() < 4) ref_q.push_back(ref_w);
        else ref_ovf = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_frame_start();
    int n = 0;
    while (count != 4'd0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    tests++;
    if (count != 4'd0) begin
      fails++;
      $display("FAIL frame_align count=%0d required=0", count);
    end
  endtask

  // Drives one 16-bit frame. abort_k: slot where cs goes high (out of range = none).
  // fill: dout during counts 0..3. ready_k: slot where m_ready pulses (-1 = leave alone).
  task automatic send_frame(input logic [11:0] w, input int abort_k, input bit fill,
                            input int ready_k);
    wait_frame_start();
    for (int k = 0; k < 16; k++) begin
      cs   = (k == abort_k);
      dout = (k >= 4) ? w[15-k] : fill;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      else if (ready_k >= 0) m_ready = (k == ready_k);
      @(posedge clk);
      #2;
    end
    cs   = 1'b1;
    dout = 1'b0;
    if (!rand_ready && ready_k >= 0) m_ready = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    m_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; dout = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (m_data !== 12'h000) begin fails++; $display("FAIL reset_m_data got=%h required=000", m_data); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got=%b required=0", m_valid); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got=%0d required=0", level); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b required=0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [11:0] exp_d;
`ifdef ADC_CAPTURE_OFFSET_EN
    exp_d = 12'h25C;
`else
    exp_d = 12'hA5C;
`endif
    m_ready = 1'b1;
    send_frame(12'hA5C, -1, 1'b0, -1);
    @(negedge clk);
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got=%b required=1", m_valid); end
    tests++; if (m_data !== exp_d) begin fails++; $display("FAIL basic_data got=%h required=%h", m_data, exp_d); end
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL basic_level got=%0d required=1", level); end
    @(negedge clk);
    tests++; if (m_valid !== 1'b0 || level !== 3'd0) begin fails++; $display("FAIL basic_pop valid=%b level=%0d required 0/0", m_valid, level); end
  endtask

  task automatic test_ignored_counts();
    m_ready = 1'b1;
    send_frame(12'h000, -1, 1'b1, -1);
    @(negedge clk);
    tests++; if (m_valid !== 1'b1 || m_data !== (12'h000 ^ OFS)) begin
      fails++; $display("FAIL ignored_counts valid=%b data=%h required 1/%h", m_valid, m_data, 12'h000 ^ OFS);
    end
  endtask

  task automatic test_abort();
    drain();
    send_frame(12'hFFF, 9, 1'b0, -1);
    @(negedge clk);
    tests++; if (level !== 3'd0 || m_valid !== 1'b0) begin fails++; $display("FAIL abort_nopush level=%0d valid=%b required 0/0", level, m_valid); end
    send_frame(12'h123, -1, 1'b0, -1);
    @(negedge clk);
    tests++; if (m_data !== (12'h123 ^ OFS) || level !== 3'd1) begin
      fails++; $display("FAIL abort_next data=%h level=%0d required %h/1", m_data, level, 12'h123 ^ OFS);
    end
  endtask

  task automatic test_full_fifo();
    logic [11:0] w;
    drain();
    for (int i = 1; i <= 5; i++) begin
      w = 12'(i);
      send_frame(w, -1, 1'b0, -1);
    end
    @(negedge clk);
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL full_level got=%0d required=4", level); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_overflow got=%b required=1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      tests++; if (m_valid !== 1'b1 || m_data !== (12'(i) ^ OFS)) begin
        fails++; $display("FAIL full_pop%0d valid=%b data=%h required 1/%h", i, m_valid, m_data, 12'(i) ^ OFS);
      end
      m_ready = 1'b1;
      @(posedge clk);
      #2 m_ready = 1'b0;
      @(negedge clk);
    end
    tests++; if (level !== 3'd0 || m_valid !== 1'b0 || m_data !== 12'h000) begin
      fails++; $display("FAIL full_empty level=%0d valid=%b data=%h required 0/0/000", level, m_valid, m_data);
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_sticky got=%b required=1", overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [11:0] w[4];
    logic [11:0] exp_d;
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = 12'($urandom);
      send_frame(w[i], -1, 1'b0, -1);
    end
    send_frame(12'h0FF, -1, 1'b0, 15);
    @(negedge clk);
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL pushpop_level got=%0d required=4", level); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pushpop_overflow got=%b required=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      exp_d = (i < 3) ? (w[i+1] ^ OFS) : (12'h0FF ^ OFS);
      tests++; if (m_data !== exp_d || m_valid !== 1'b1) begin
        fails++; $display("FAIL pushpop_out%0d data=%h valid=%b required %h/1", i, m_data, m_valid, exp_d);
      end
      m_ready = 1'b1;
      @(posedge clk);
      #2 m_ready = 1'b0;
      @(negedge clk);
    end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL pushpop_drained level=%0d required=0", level); end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] w0, w1, w2;
    w0 = 12'($urandom);
    w1 = 12'($urandom);
    w2 = 12'($urandom);
    m_ready = 1'b0;
    send_frame(w0, -1, 1'b0, -1);
    wait_frame_start();
    for (int k = 0; k < 16; k++) begin
      cs   = 1'b0;
      dout = (k >= 4) ? w1[15-k] : 1'b0;
      rst  = (k == 10);
      @(posedge clk);
      #2;
      if (k == 10) begin
        tests++; if (m_data !== 12'h000 || m_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
          fails++; $display("FAIL rstmid_outputs data=%h valid=%b level=%0d ovf=%b required all 0", m_data, m_valid, level, overflow);
        end
      end
    end
    rst = 1'b0;
    cs  = 1'b1;
    @(negedge clk);
    tests++; if (level !== 3'd0 || m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_nopush level=%0d valid=%b required 0/0", level, m_valid); end
    send_frame(w2, -1, 1'b0, -1);
    @(negedge clk);
    tests++; if (m_data !== (w2 ^ OFS) || level !== 3'd1) begin
      fails++; $display("FAIL rstmid_next data=%h level=%0d required %h/1", m_data, level, w2 ^ OFS);
    end
    drain();
  endtask

  task automatic test_random();
    logic [11:0] w;
    logic [11:0] exp_d;
    int ab;
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      w  = 12'($urandom);
      ab = int'($urandom_range(0, 40));
      send_frame(w, ab, 1'($urandom_range(0, 1)), -1);
      @(negedge clk);
      exp_d = (ref_q.size() != 0) ? ref_q[0] : 12'h000;
      tests++; if (m_data !== exp_d || m_valid !== (ref_q.size() != 0) || int'(level) != ref_q.size() || overflow !== ref_ovf) begin
        fails++;
        $display("FAIL random_frame%0d data=%h valid=%b level=%0d ovf=%b required %h/%b/%0d/%b",
                 n, m_data, m_valid, level, overflow, exp_d, (ref_q.size() != 0), ref_q.size(), ref_ovf);
      end
    end
    rand_ready = 1'b0;
    m_ready    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; dout = 1'b0; m_ready = 1'b0;
    test_reset();
    test_basic();
    test_ignored_counts();
    test_abort();
    test_full_fifo();
    test_push_pop_full();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
